riscv_commit_checker: RTL and testbench
=======================================

Name: riscv_commit_checker

Overview:
- Synthesisable, parametrised self-checking monitor for the single-cycle RISC-V core. It replaces free-running $monitor prints and fixed $stop delays.
- Taps the core's observation ports: pc, instr, aluout, writedata, memwrite.
- Compares every data-memory store against a programmable table of expected stores.
- Detects end of program (jump-to-self) and enforces a cycle watchdog.
- Reports a single pass/fail verdict with diagnostic capture. Instantiated beside the core in benches and FPGA bring-up.

Parameters:
- XLEN, 32, data/address width of the observed buses.
- NUM_CHECKS, 8, depth of the expected-store table (power of 2, 2..64).
- TIMEOUT_CYCLES, 100, maximum RUN cycles before a timeout failure.
- HALT_REPEAT, 2, consecutive cycles the halt instruction must persist at the same pc.
- HALT_INSTR, 32'h0000006F, halt encoding (jal x0,0).

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- pc  in  XLEN  core program counter
- instr  in  32  current instruction
- aluout  in  XLEN  store address when memwrite=1
- writedata  in  XLEN  store data when memwrite=1
- memwrite  in  1  core store strobe
- exp_wr_en  in  1  write one expected-store entry (accepted only in IDLE)
- exp_wr_idx  in  $clog2(NUM_CHECKS)  table index
- exp_addr  in  XLEN  expected store address
- exp_data  in  XLEN  expected store data
- exp_count  in  $clog2(NUM_CHECKS)+1  number of valid entries, sampled on start
- start  in  1  begin checking (accepted in IDLE or DONE)
- busy  out  1  high in RUN
- done  out  1  high in DONE
- pass  out  1  valid when done
- fail_code  out  3  0 none, 1 data/addr mismatch, 2 extra store, 3 missing store, 4 timeout
- cycle_count  out  32  RUN cycles elapsed
- store_count  out  $clog2(NUM_CHECKS)+1  stores matched so far
- bad_addr  out  XLEN  address of the first failing store
- bad_data  out  XLEN  data of the first failing store

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs and counters are 0; the exp_count latch is 0.
  - Table RAM contents are not reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - exp_wr_en=1 writes {exp_addr, exp_data} at exp_wr_idx on the clock edge.
  - exp_wr_en is ignored in RUN and DONE.
- Entering RUN (start=1 in IDLE or DONE):
  - Next cycle: state=RUN, busy=1.
  - exp_count is latched.
  - cycle_count, store_count, halt counter, fail_code, pass, bad_addr, bad_data all clear.
  - start while in RUN is ignored.
  - start and exp_wr_en in the same IDLE cycle: the write occurs and the run starts.
- Each RUN cycle: cycle_count increments (saturates at 2^32-1).
- Store check (memwrite=1 in RUN):
  - store_count >= latched exp_count: fail_code=2, capture aluout/writedata, go to DONE.
  - aluout or writedata differs from table[store_count]: fail_code=1, capture, go to DONE.
  - Otherwise store_count increments.
- Halt detection:
  - The halt counter increments when instr==HALT_INSTR and pc equals the pc of the previous cycle. Any other cycle resets it to 0.
  - When the counter reaches HALT_REPEAT-1:
    - store_count==exp_count: pass=1, fail_code=0.
    - Otherwise fail_code=3.
    - Either way, go to DONE.
- Timeout: when cycle_count==TIMEOUT_CYCLES-1 in RUN with no other terminating event, fail_code=4 and go to DONE.
- Same-cycle priority: store failure > halt verdict > timeout. A passing store in the same cycle as a halt verdict is counted before the verdict is evaluated.
- DONE:
  - done=1, busy=0.
  - All results hold until reset or a new start.
  - memwrite is ignored.
- Verdict latency: registered; done rises on the edge after the terminating event.
- exp_count=0 is legal: any store is an extra-store failure.
- Async reset mid-RUN aborts immediately, with no verdict.

Test Plan:
- Load entry0={0x18,0x00000007}, exp_count=1, start. Drive a store 0x18/0x7 at cycle 5, then HALT_INSTR at pc 0x40 for 2 cycles -> done=1, pass=1, fail_code=0, store_count=1, cycle_count=8.
- Same setup, but the store data is 0x6 -> done the next cycle, fail_code=1, bad_addr=0x18, bad_data=0x6, store_count=0.
- exp_count=1, two correct-then-extra stores (0x18/0x7, then 0x1C/0x1) -> fail_code=2, bad_addr=0x1C, store_count=1.
- exp_count=2, only one matching store, then halt -> fail_code=3, pass=0, store_count=1.
- TIMEOUT_CYCLES=100, no halt, no stores -> done after 100 RUN cycles, fail_code=4, cycle_count=99.
- Assert reset_n low mid-RUN at cycle 10 -> busy/done/cycle_count are 0 immediately. Restart with start -> a clean pass on the first scenario.

Source files
------------

// File: rtl/riscv_commit_checker.sv
// Commit checker for the single-cycle RISC-V core: compares each store against a
// preloaded table, detects the jump-to-self halt, and enforces a cycle watchdog.
module riscv_commit_checker #(
    parameter int          XLEN           = 32,
    parameter int          NUM_CHECKS     = 8,
    parameter int          TIMEOUT_CYCLES = 100,
    parameter int          HALT_REPEAT    = 2,
    parameter logic [31:0] HALT_INSTR     = 32'h0000006F
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [XLEN-1:0]               pc,
    input  logic [31:0]                   instr,
    input  logic [XLEN-1:0]               aluout,
    input  logic [XLEN-1:0]               writedata,
    input  logic                          memwrite,
    input  logic                          exp_wr_en,
    input  logic [$clog2(NUM_CHECKS)-1:0] exp_wr_idx,
    input  logic [XLEN-1:0]               exp_addr,
    input  logic [XLEN-1:0]               exp_data,
    input  logic [$clog2(NUM_CHECKS):0]   exp_count,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [2:0]                    fail_code,
    output logic [31:0]                   cycle_count,
    output logic [$clog2(NUM_CHECKS):0]   store_count,
    output logic [XLEN-1:0]               bad_addr,
    output logic [XLEN-1:0]               bad_data
);

    localparam int          IDXW        = $clog2(NUM_CHECKS);
    localparam int          CNTW        = IDXW + 1;
    localparam logic [31:0] HALT_TARGET = 32'(HALT_REPEAT - 1);
    localparam logic [31:0] TIMEOUT_END = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] MAX_CNT = CNTW'(NUM_CHECKS);

    localparam logic [2:0] FC_NONE     = 3'd0;
    localparam logic [2:0] FC_MISMATCH = 3'd1;
    localparam logic [2:0] FC_EXTRA    = 3'd2;
    localparam logic [2:0] FC_MISSING  = 3'd3;
    localparam logic [2:0] FC_TIMEOUT  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counts above the table depth would index past the table, so clamp them.
    function automatic logic [CNTW-1:0] clamp_count(input logic [CNTW-1:0] cnt);
        if (cnt > MAX_CNT) begin
            return MAX_CNT;
        end else begin
            return cnt;
        end
    endfunction

    logic [XLEN-1:0] tbl_addr_r [NUM_CHECKS];
    logic [XLEN-1:0] tbl_data_r [NUM_CHECKS];

    state_t          state_r, state_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            done_r, done_nxt_s;
    logic            pass_r, pass_nxt_s;
    logic [2:0]      fail_code_r, fail_code_nxt_s;
    logic [31:0]     cycle_count_r, cycle_count_nxt_s;
    logic [CNTW-1:0] store_count_r, store_count_nxt_s;
    logic [XLEN-1:0] bad_addr_r, bad_addr_nxt_s;
    logic [XLEN-1:0] bad_data_r, bad_data_nxt_s;
    logic [CNTW-1:0] exp_count_r, exp_count_nxt_s;
    logic [31:0]     halt_cnt_r, halt_cnt_nxt_s;
    logic            prev_valid_r, prev_valid_nxt_s;
    logic [XLEN-1:0] pc_prev_r;

    logic            same_pc_s;
    logic            halt_hit_s;
    logic            extra_s;
    logic            exp_hit_s;
    logic            store_ok_s;
    logic [CNTW-1:0] store_cnt_inc_s;
    logic [IDXW-1:0] rd_idx_s;

    // Expected-store table; contents survive reset and are only loaded in IDLE.
    always_ff @(posedge clk) begin
        if (state_r == ST_IDLE && exp_wr_en) begin
            tbl_addr_r[exp_wr_idx] <= exp_addr;
            tbl_data_r[exp_wr_idx] <= exp_data;
        end
    end

    // Per-cycle event decode: halt persistence and store comparison.
    always_comb begin
        rd_idx_s        = store_count_r[IDXW-1:0];
        same_pc_s       = prev_valid_r && (instr == HALT_INSTR) && (pc == pc_prev_r);
        halt_hit_s      = same_pc_s && ((halt_cnt_r + 32'd1) >= HALT_TARGET);
        extra_s         = (store_count_r >= exp_count_r);
        exp_hit_s       = (aluout == tbl_addr_r[rd_idx_s]) && (writedata == tbl_data_r[rd_idx_s]);
        store_ok_s      = memwrite && !extra_s && exp_hit_s;
        store_cnt_inc_s = store_ok_s ? (store_count_r + CNTW'(1)) : store_count_r;
    end

    // Next-state and next-result logic; a passing store is counted before the halt verdict.
    always_comb begin
        state_nxt_s       = state_r;
        busy_nxt_s        = busy_r;
        done_nxt_s        = done_r;
        pass_nxt_s        = pass_r;
        fail_code_nxt_s   = fail_code_r;
        cycle_count_nxt_s = cycle_count_r;
        store_count_nxt_s = store_count_r;
        bad_addr_nxt_s    = bad_addr_r;
        bad_data_nxt_s    = bad_data_r;
        exp_count_nxt_s   = exp_count_r;
        halt_cnt_nxt_s    = halt_cnt_r;
        prev_valid_nxt_s  = prev_valid_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt_s       = ST_RUN;
                    busy_nxt_s        = 1'b1;
                    done_nxt_s        = 1'b0;
                    pass_nxt_s        = 1'b0;
                    fail_code_nxt_s   = FC_NONE;
                    cycle_count_nxt_s = 32'd0;
                    store_count_nxt_s = '0;
                    bad_addr_nxt_s    = '0;
                    bad_data_nxt_s    = '0;
                    exp_count_nxt_s   = clamp_count(exp_count);
                    halt_cnt_nxt_s    = 32'd0;
                    prev_valid_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                prev_valid_nxt_s = 1'b1;
                halt_cnt_nxt_s   = same_pc_s ? (halt_cnt_r + 32'd1) : 32'd0;
                if (memwrite && (extra_s || !exp_hit_s)) begin
                    state_nxt_s     = ST_DONE;
                    busy_nxt_s      = 1'b0;
                    done_nxt_s      = 1'b1;
                    fail_code_nxt_s = extra_s ? FC_EXTRA : FC_MISMATCH;
                    bad_addr_nxt_s  = aluout;
                    bad_data_nxt_s  = writedata;
                end else if (halt_hit_s) begin
                    state_nxt_s       = ST_DONE;
                    busy_nxt_s        = 1'b0;
                    done_nxt_s        = 1'b1;
                    store_count_nxt_s = store_cnt_inc_s;
                    if (store_cnt_inc_s == exp_count_r) begin
                        pass_nxt_s      = 1'b1;
                        fail_code_nxt_s = FC_NONE;
                    end else begin
                        pass_nxt_s      = 1'b0;
                        fail_code_nxt_s = FC_MISSING;
                    end
                end else if (cycle_count_r == TIMEOUT_END) begin
                    state_nxt_s       = ST_DONE;
                    busy_nxt_s        = 1'b0;
                    done_nxt_s        = 1'b1;
                    store_count_nxt_s = store_cnt_inc_s;
                    fail_code_nxt_s   = FC_TIMEOUT;
                end else begin
                    store_count_nxt_s = store_cnt_inc_s;
                    if (cycle_count_r != 32'hFFFF_FFFF) begin
                        cycle_count_nxt_s = cycle_count_r + 32'd1;
                    end else begin
                        cycle_count_nxt_s = cycle_count_r;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                done_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            fail_code_r   <= 3'd0;
            cycle_count_r <= 32'd0;
            store_count_r <= '0;
            bad_addr_r    <= '0;
            bad_data_r    <= '0;
            exp_count_r   <= '0;
            halt_cnt_r    <= 32'd0;
            prev_valid_r  <= 1'b0;
            pc_prev_r     <= '0;
        end else begin
            state_r       <= state_nxt_s;
            busy_r        <= busy_nxt_s;
            done_r        <= done_nxt_s;
            pass_r        <= pass_nxt_s;
            fail_code_r   <= fail_code_nxt_s;
            cycle_count_r <= cycle_count_nxt_s;
            store_count_r <= store_count_nxt_s;
            bad_addr_r    <= bad_addr_nxt_s;
            bad_data_r    <= bad_data_nxt_s;
            exp_count_r   <= exp_count_nxt_s;
            halt_cnt_r    <= halt_cnt_nxt_s;
            prev_valid_r  <= prev_valid_nxt_s;
            pc_prev_r     <= pc;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign pass        = pass_r;
    assign fail_code   = fail_code_r;
    assign cycle_count = cycle_count_r;
    assign store_count = store_count_r;
    assign bad_addr    = bad_addr_r;
    assign bad_data    = bad_data_r;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Directed, table-driven bench for riscv_commit_checker with default parameters.
module tb_riscv_commit_checker;

    localparam logic [31:0] HALT = 32'h0000006F;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = 32'd0;
    logic [31:0] instr = 32'h00000013;
    logic [31:0] aluout = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic        memwrite = 1'b0;
    logic        exp_wr_en = 1'b0;
    logic [2:0]  exp_wr_idx = 3'd0;
    logic [31:0] exp_addr = 32'd0;
    logic [31:0] exp_data = 32'd0;
    logic [3:0]  exp_count = 4'd0;
    logic        start = 1'b0;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [31:0] cycle_count;
    logic [3:0]  store_count;
    logic [31:0] bad_addr;
    logic [31:0] bad_data;

    int checks = 0;
    int failures = 0;

    riscv_commit_checker dut (
        .clk(clk), .reset_n(reset_n), .pc(pc), .instr(instr), .aluout(aluout),
        .writedata(writedata), .memwrite(memwrite), .exp_wr_en(exp_wr_en),
        .exp_wr_idx(exp_wr_idx), .exp_addr(exp_addr), .exp_data(exp_data),
        .exp_count(exp_count), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .cycle_count(cycle_count), .store_count(store_count),
        .bad_addr(bad_addr), .bad_data(bad_data)
    );

    always #5 clk = ~clk;

    // One scenario: up to two stores, optional halt from cycle hc on, and the expected verdict.
    typedef struct {
        int          cnt;
        int          s0c;
        logic [31:0] s0a;
        logic [31:0] s0d;
        int          s1c;
        logic [31:0] s1a;
        logic [31:0] s1d;
        int          hc;
        bit          junk;
        bit          pass;
        int          fc;
        int          sc;
        int          cc;
        logic [31:0] ba;
        logic [31:0] bd;
    } scen_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; exp_wr_en = 1'b0; memwrite = 1'b0;
        instr = NOP; aluout = 32'd0; writedata = 32'd0;
    endtask

    task automatic run_scen(input int id, input scen_t s, input bit start_wr);
        int  end_c;
        bit  seen;
        logic [2:0]  fc_hold;
        logic [31:0] ba_hold;
        logic [31:0] cc_hold;
        @(negedge clk);
        idle_inputs();
        pc = 32'd0;
        start = 1'b1; exp_count = 4'(s.cnt);
        exp_wr_en = start_wr; exp_wr_idx = 3'd0; exp_addr = 32'h18; exp_data = 32'h7;
        @(negedge clk);
        chk($sformatf("s%0d busy_after_start", id), {31'd0, busy}, 32'd1);
        chk($sformatf("s%0d cc_after_start", id), cycle_count, 32'd0);
        seen = 1'b0;
        end_c = -1;
        for (int c = 0; c < 200 && !seen; c++) begin
            idle_inputs();
            exp_wr_en = s.junk; exp_wr_idx = 3'd0; exp_addr = 32'hDEAD; exp_data = 32'hBEEF;
            start = s.junk && (c == 2);
            if (s.hc >= 0 && c >= s.hc) begin
                instr = HALT; pc = 32'h40;
            end else begin
                instr = NOP; pc = 32'(4 * c);
            end
            if (c == s.s0c) begin
                memwrite = 1'b1; aluout = s.s0a; writedata = s.s0d;
            end else if (c == s.s1c) begin
                memwrite = 1'b1; aluout = s.s1a; writedata = s.s1d;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                end_c = c;
            end
        end
        idle_inputs();
        chk($sformatf("s%0d done_seen", id), {31'd0, seen}, 32'd1);
        chk($sformatf("s%0d done_cycle", id), 32'(end_c), 32'(s.cc));
        chk($sformatf("s%0d busy", id), {31'd0, busy}, 32'd0);
        chk($sformatf("s%0d pass", id), {31'd0, pass}, {31'd0, s.pass});
        chk($sformatf("s%0d fail_code", id), {29'd0, fail_code}, 32'(s.fc));
        chk($sformatf("s%0d store_count", id), {28'd0, store_count}, 32'(s.sc));
        chk($sformatf("s%0d cycle_count", id), cycle_count, 32'(s.cc));
        chk($sformatf("s%0d bad_addr", id), bad_addr, s.ba);
        chk($sformatf("s%0d bad_data", id), bad_data, s.bd);
        // Stores and table writes in DONE must change nothing.
        fc_hold = 3'(s.fc); ba_hold = s.ba; cc_hold = 32'(s.cc);
        memwrite = 1'b1; aluout = 32'h99; writedata = 32'h99;
        exp_wr_en = 1'b1; exp_wr_idx = 3'd1; exp_addr = 32'hAAAA; exp_data = 32'hBBBB;
        @(negedge clk);
        idle_inputs();
        chk($sformatf("s%0d hold_done", id), {31'd0, done}, 32'd1);
        chk($sformatf("s%0d hold_fc", id), {29'd0, fail_code}, {29'd0, fc_hold});
        chk($sformatf("s%0d hold_bad_addr", id), bad_addr, ba_hold);
        chk($sformatf("s%0d hold_cc", id), cycle_count, cc_hold);
    endtask

    scen_t vec[9];
    scen_t scen_a;

    initial begin
        //            cnt s0c s0a     s0d    s1c s1a     s1d    hc  junk pass fc sc cc  ba      bd
        vec[0] = '{1,  5, 32'h18, 32'h7, -1, 32'h0,  32'h0, 7,  1'b1, 1'b1, 0, 1, 8,  32'h0,  32'h0};
        vec[1] = '{1,  5, 32'h18, 32'h6, -1, 32'h0,  32'h0, -1, 1'b0, 1'b0, 1, 0, 5,  32'h18, 32'h6};
        vec[2] = '{1,  5, 32'h18, 32'h7,  6, 32'h1C, 32'h1, -1, 1'b0, 1'b0, 2, 1, 6,  32'h1C, 32'h1};
        vec[3] = '{2,  5, 32'h18, 32'h7, -1, 32'h0,  32'h0, 7,  1'b0, 1'b0, 3, 1, 8,  32'h0,  32'h0};
        vec[4] = '{0, -1, 32'h0,  32'h0, -1, 32'h0,  32'h0, -1, 1'b0, 1'b0, 4, 0, 99, 32'h0,  32'h0};
        vec[5] = '{0,  2, 32'h18, 32'h7, -1, 32'h0,  32'h0, -1, 1'b0, 1'b0, 2, 0, 2,  32'h18, 32'h7};
        vec[6] = '{2,  3, 32'h18, 32'h7,  7, 32'h1C, 32'h1, 6,  1'b0, 1'b1, 0, 2, 7,  32'h0,  32'h0};
        vec[7] = '{2,  3, 32'h18, 32'h7,  7, 32'h1C, 32'h2, 6,  1'b0, 1'b0, 1, 1, 7,  32'h1C, 32'h2};
        vec[8] = '{0, -1, 32'h0,  32'h0, -1, 32'h0,  32'h0, 98, 1'b0, 1'b1, 0, 0, 99, 32'h0,  32'h0};
        scen_a = vec[0];
        scen_a.junk = 1'b0;

        // Reset state.
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset pass", {31'd0, pass}, 32'd0);
        chk("reset fail_code", {29'd0, fail_code}, 32'd0);
        chk("reset cycle_count", cycle_count, 32'd0);
        chk("reset store_count", {28'd0, store_count}, 32'd0);
        chk("reset bad_addr", bad_addr, 32'd0);

        // Load entry1 in IDLE; entry0 is written in the same cycle as the first start.
        @(negedge clk);
        exp_wr_en = 1'b1; exp_wr_idx = 3'd1; exp_addr = 32'h1C; exp_data = 32'h1;
        @(negedge clk);
        idle_inputs();

        run_scen(0, vec[0], 1'b1);
        for (int i = 1; i < 9; i++) begin
            run_scen(i, vec[i], 1'b0);
        end

        // Asynchronous reset in the middle of a run aborts without a verdict.
        @(negedge clk);
        start = 1'b1; exp_count = 4'd1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            pc = 32'(4 * c);
            @(negedge clk);
        end
        chk("midrun cycle_count_before", cycle_count, 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrun busy", {31'd0, busy}, 32'd0);
        chk("midrun done", {31'd0, done}, 32'd0);
        chk("midrun cycle_count", cycle_count, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        chk("midrun idle_busy", {31'd0, busy}, 32'd0);

        run_scen(9, scen_a, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
